dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and memory.

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/dcache_if.sv | 39 +++
 rtl/dcache_frames.sv | 51 +++++
 rtl/dcache.sv | 175 +++++++++++++++++
 tb/tb_dcache.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: address split, FSM states, geometry.
package cpu_types_pkg;

  localparam int SETS = 16;
  localparam int IW   = $clog2(SETS);
  localparam int DWPB = 2;
  localparam int TW   = 32 - 3 - IW;

  typedef logic [31:0] word_t;

  // Byte address as seen by the cache.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic          blkoff;
    logic [1:0]    bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, FILL0, FILL1, FLUSH, FWB0, FWB1, DONE
  } dcache_state_t;

  // Word address of one word within a block.
  function automatic word_t blk_addr(input logic [TW-1:0] tag,
                                     input logic [IW-1:0] idx,
                                     input logic word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Datapath and memory-side signals of the data cache, plus FSM state for observation.
//
// Handshake semantics:
//  - Datapath side: dmemREN/dmemWEN act as "valid" and are held stable (with
//    dmemaddr/dmemstore) until dhit, which acts as "ready"; the request
//    completes in the cycle where both are high.
//  - Memory side: dREN/dWEN act as "valid" with daddr/dstore stable; dwait low
//    is "ready"; a word moves on the posedge where valid is high and dwait is low.
interface dcache_if;
  import cpu_types_pkg::*;

  logic          dmemREN;
  logic          dmemWEN;
  word_t         dmemaddr;
  word_t         dmemstore;
  logic          halt;
  logic          dhit;
  word_t         dmemload;
  logic          flushed;
  logic          dREN;
  logic          dWEN;
  word_t         daddr;
  word_t         dstore;
  word_t         dload;
  logic          dwait;
  dcache_state_t state;

  // Environment view: drives requests and memory responses.
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore, state
  );

  // Cache view.
  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore, state
  );
endinterface

// File: rtl/dcache_frames.sv
// Frame storage: valid/dirty/tag/data per set; one combinational read port and
// one write port sharing the same index.
module dcache_frames
  import cpu_types_pkg::*;
(
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [IW-1:0]         idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TW-1:0]         rd_tag,
  output logic [DWPB-1:0][31:0] rd_data,
  input  logic                  data_we,
  input  logic                  data_word,
  input  word_t                 data_in,
  input  logic                  valid_we,
  input  logic                  valid_in,
  input  logic                  dirty_we,
  input  logic                  dirty_in,
  input  logic                  tag_we,
  input  logic [TW-1:0]         tag_in
);

  logic [SETS-1:0]         valid_q;
  logic [SETS-1:0]         dirty_q;
  logic [TW-1:0]           tag_q  [SETS];
  logic [DWPB-1:0][31:0]   data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  // Status bits: cleared on reset so every frame starts invalid and clean.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_we) valid_q[idx] <= valid_in;
      if (dirty_we) dirty_q[idx] <= dirty_in;
    end
  end

  // Tag and data arrays: no reset, contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (tag_we)  tag_q[idx] <= tag_in;
    if (data_we) data_q[idx][data_word] <= data_in;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate data cache with halt-triggered flush.
module dcache
  import cpu_types_pkg::*;
(
  input logic     CLK,
  input logic     nRST,
  dcache_if.slave bus
);

  dcache_state_t         state, next_state;
  logic [IW-1:0]         flush_cnt, flush_cnt_next;
  dcachef_t              req;
  logic [IW-1:0]         frame_idx;
  logic                  in_flush;
  logic                  flush_last;
  logic                  hit;
  logic                  unused_bytoff;

  logic                  rd_valid, rd_dirty;
  logic [TW-1:0]         rd_tag;
  logic [DWPB-1:0][31:0] rd_data;
  logic                  data_we, data_word, valid_we, valid_in;
  logic                  dirty_we, dirty_in, tag_we;
  word_t                 data_in;

  logic                  dhit, flushed, dren, dwen;
  word_t                 dmemload, daddr, dstore;

  assign req           = dcachef_t'(bus.dmemaddr);
  assign unused_bytoff = ^req.bytoff;

  // Flush walks frames by counter; everything else looks at the request index.
  assign in_flush   = (state == FLUSH) || (state == FWB0) || (state == FWB1);
  assign frame_idx  = in_flush ? flush_cnt : req.idx;
  assign flush_last = (flush_cnt == IW'(SETS - 1));
  assign hit        = rd_valid && (rd_tag == req.tag) && (bus.dmemREN || bus.dmemWEN);

  dcache_frames u_frames (
    .clk       (CLK),
    .nRST      (nRST),
    .idx       (frame_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .data_we   (data_we),
    .data_word (data_word),
    .data_in   (data_in),
    .valid_we  (valid_we),
    .valid_in  (valid_in),
    .dirty_we  (dirty_we),
    .dirty_in  (dirty_in),
    .tag_we    (tag_we),
    .tag_in    (req.tag)
  );

  // State and flush counter registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= next_state;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next state, frame write controls and bus outputs, all decoded from state.
  always_comb begin
    next_state     = state;
    flush_cnt_next = flush_cnt;
    dhit           = 1'b0;
    dmemload       = '0;
    flushed        = 1'b0;
    dren           = 1'b0;
    dwen           = 1'b0;
    daddr          = '0;
    dstore         = '0;
    data_we        = 1'b0;
    data_word      = 1'b0;
    data_in        = '0;
    valid_we       = 1'b0;
    valid_in       = 1'b0;
    dirty_we       = 1'b0;
    dirty_in       = 1'b0;
    tag_we         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.halt) begin
          next_state     = FLUSH;
          flush_cnt_next = '0;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          if (hit) begin
            dhit = 1'b1;
            if (bus.dmemWEN) begin
              data_we   = 1'b1;
              data_word = req.blkoff;
              data_in   = bus.dmemstore;
              dirty_we  = 1'b1;
              dirty_in  = 1'b1;
            end else begin
              dmemload = rd_data[req.blkoff];
            end
          end else if (rd_valid && rd_dirty) begin
            next_state = WB0;
          end else begin
            next_state = FILL0;
          end
        end
      end
      WB0, WB1: begin
        dwen   = 1'b1;
        daddr  = blk_addr(rd_tag, req.idx, state == WB1);
        dstore = rd_data[state == WB1];
        if (!bus.dwait) next_state = (state == WB0) ? WB1 : FILL0;
      end
      FILL0, FILL1: begin
        dren  = 1'b1;
        daddr = blk_addr(req.tag, req.idx, state == FILL1);
        if (!bus.dwait) begin
          data_we   = 1'b1;
          data_word = (state == FILL1);
          data_in   = bus.dload;
          if (state == FILL0) begin
            next_state = FILL1;
          end else begin
            valid_we   = 1'b1;
            valid_in   = 1'b1;
            dirty_we   = 1'b1;
            dirty_in   = 1'b0;
            tag_we     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      FLUSH: begin
        if (rd_valid && rd_dirty) begin
          next_state = FWB0;
        end else begin
          flush_cnt_next = flush_cnt + IW'(1);
          if (flush_last) next_state = DONE;
        end
      end
      FWB0, FWB1: begin
        dwen   = 1'b1;
        daddr  = blk_addr(rd_tag, flush_cnt, state == FWB1);
        dstore = rd_data[state == FWB1];
        if (!bus.dwait) begin
          if (state == FWB0) begin
            next_state = FWB1;
          end else begin
            dirty_we       = 1'b1;
            dirty_in       = 1'b0;
            flush_cnt_next = flush_cnt + IW'(1);
            next_state     = flush_last ? DONE : FLUSH;
          end
        end
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.dhit     = dhit;
  assign bus.dmemload = dmemload;
  assign bus.flushed  = flushed;
  assign bus.dREN     = dren;
  assign bus.dWEN     = dwen;
  assign bus.daddr    = daddr;
  assign bus.dstore   = dstore;
  assign bus.state    = state;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: fills, store hits, dirty evictions, flush, reset abort.
module tb_dcache;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;
  dcache_if bus();

  dcache dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int wait_cnt;
  int both_cnt = 0;

  // Transfer record: {31'b0, is_write, addr, data}.
  logic [95:0] exp_q[$];
  logic [95:0] log_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic word_t mem_word(input word_t a);
    if (a == 32'h40 || a == 32'h44) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 | a;
  endfunction

  function automatic logic [95:0] xw(input word_t a, input word_t d);
    return {31'b0, 1'b1, a, d};
  endfunction

  function automatic logic [95:0] xr(input word_t a);
    return {31'b0, 1'b0, a, mem_word(a)};
  endfunction

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare recorded memory transfers against the expected list, then clear both.
  task automatic check_xfers(input string tag);
    logic [95:0] g, e;
    check_eq({tag, "_count"}, 96'(log_q.size()), 96'(exp_q.size()));
    while (log_q.size() > 0 && exp_q.size() > 0) begin
      g = log_q.pop_front();
      e = exp_q.pop_front();
      check_eq(tag, g, e);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // ---------------- memory responder: dwait low on the 3rd cycle of each transfer ----------------
  initial begin
    wait_cnt  = 0;
    bus.dwait = 1'b1;
    bus.dload = '0;
    forever begin
      @(negedge clk);
      if (bus.dREN && bus.dWEN) both_cnt++;
      if (nrst && (bus.dREN || bus.dWEN)) begin
        bus.dload = mem_word(bus.daddr);
        if (wait_cnt == 2) begin
          bus.dwait = 1'b0;
          wait_cnt  = 0;
          log_q.push_back(bus.dWEN ? xw(bus.daddr, bus.dstore) : xr(bus.daddr));
        end else begin
          bus.dwait = 1'b1;
          wait_cnt++;
        end
      end else begin
        bus.dwait = 1'b1;
        wait_cnt  = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic ren, input logic wen, input word_t addr, input word_t data,
                        output word_t load, output int cycles);
    logic got;
    @(posedge clk); #1;
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.dmemaddr  = addr;
    bus.dmemstore = data;
    got    = 1'b0;
    cycles = 0;
    load   = '0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (bus.dhit) begin
        got  = 1'b1;
        load = bus.dmemload;
      end
    end
    check_eq("dhit_seen", 96'(got), 96'd1);
    @(posedge clk); #1;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dhit"},    96'(bus.dhit),    96'd0);
    check_eq({tag, "_dREN"},    96'(bus.dREN),    96'd0);
    check_eq({tag, "_dWEN"},    96'(bus.dWEN),    96'd0);
    check_eq({tag, "_daddr"},   96'(bus.daddr),   96'd0);
    check_eq({tag, "_dstore"},  96'(bus.dstore),  96'd0);
    check_eq({tag, "_flushed"}, 96'(bus.flushed), 96'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    word_t ld;
    int    cyc;
    logic  seen;

    nrst          = 1'b0;
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.halt      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    nrst = 1'b1;

    // Cold load: two reads, then hit.
    access(1'b1, 1'b0, 32'h40, '0, ld, cyc);
    check_eq("cold_ld_data", ld, 32'hDEAD_BEEF);
    check_eq("cold_ld_cycles", 96'(cyc), 96'd8);
    exp_q.push_back(xr(32'h40));
    exp_q.push_back(xr(32'h44));
    check_xfers("cold_xfer");

    // Store hit, then reloads.
    access(1'b0, 1'b1, 32'h44, 32'h1234, ld, cyc);
    check_eq("st_hit_cycles", 96'(cyc), 96'd1);
    access(1'b1, 1'b0, 32'h44, '0, ld, cyc);
    check_eq("reload44_data", ld, 32'h1234);
    check_eq("reload44_cycles", 96'(cyc), 96'd1);
    access(1'b1, 1'b0, 32'h40, '0, ld, cyc);
    check_eq("reload40_data", ld, 32'hDEAD_BEEF);
    check_xfers("hit_xfer");

    // Conflict miss with dirty victim at idx 8.
    access(1'b1, 1'b0, 32'hC0, '0, ld, cyc);
    check_eq("conflict_data", ld, 32'hA5A5_00C0);
    check_eq("conflict_cycles", 96'(cyc), 96'd14);
    exp_q.push_back(xw(32'h40, 32'hDEAD_BEEF));
    exp_q.push_back(xw(32'h44, 32'h0000_1234));
    exp_q.push_back(xr(32'hC0));
    exp_q.push_back(xr(32'hC4));
    check_xfers("conflict_xfer");
    access(1'b1, 1'b0, 32'hC4, '0, ld, cyc);
    check_eq("c4_data", ld, 32'hA5A5_00C4);

    // REN and WEN together on a hit behave as a store.
    access(1'b1, 1'b1, 32'hC0, 32'h1111_0000, ld, cyc);
    check_eq("renwen_cycles", 96'(cyc), 96'd1);
    access(1'b1, 1'b0, 32'hC0, '0, ld, cyc);
    check_eq("renwen_data", ld, 32'h1111_0000);
    check_xfers("renwen_xfer");

    // Store miss into empty frame 3.
    access(1'b0, 1'b1, 32'h1C, 32'h2222_3333, ld, cyc);
    check_eq("st_miss_cycles", 96'(cyc), 96'd8);
    access(1'b1, 1'b0, 32'h18, '0, ld, cyc);
    check_eq("st_miss_w0", ld, 32'hA5A5_0018);
    exp_q.push_back(xr(32'h18));
    exp_q.push_back(xr(32'h1C));
    check_xfers("st_miss_xfer");

    // Halt: flush writes idx 3 then idx 8.
    @(posedge clk); #1;
    bus.halt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (bus.flushed) seen = 1'b1;
    end
    check_eq("flushed_seen", 96'(seen), 96'd1);
    exp_q.push_back(xw(32'h18, 32'hA5A5_0018));
    exp_q.push_back(xw(32'h1C, 32'h2222_3333));
    exp_q.push_back(xw(32'hC0, 32'h1111_0000));
    exp_q.push_back(xw(32'hC4, 32'hA5A5_00C4));
    check_xfers("flush_xfer");
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'hC0;
    @(negedge clk);
    check_eq("done_no_dhit", 96'(bus.dhit), 96'd0);
    bus.halt = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("flushed_sticky", 96'(bus.flushed), 96'd1);
    bus.dmemREN = 1'b0;
    check_xfers("done_quiet");

    // Reset out of DONE.
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst1");
    nrst = 1'b1;

    // Reset during FILL1 abandons the fill.
    @(posedge clk); #1;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h40;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.dREN && bus.daddr == 32'h44) seen = 1'b1;
    end
    check_eq("fill1_reached", 96'(seen), 96'd1);
    nrst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_dREN", 96'(bus.dREN), 96'd0);
    check_eq("abort_flushed", 96'(bus.flushed), 96'd0);
    bus.dmemREN = 1'b0;
    nrst = 1'b1;
    exp_q.push_back(xr(32'h40));
    check_xfers("abort_xfer");
    access(1'b1, 1'b0, 32'h40, '0, ld, cyc);
    check_eq("abort_remiss_cycles", 96'(cyc), 96'd8);
    check_eq("abort_remiss_data", ld, 32'hDEAD_BEEF);
    exp_q.push_back(xr(32'h40));
    exp_q.push_back(xr(32'h44));
    check_xfers("remiss_xfer");

    check_eq("ren_wen_exclusive", 96'(both_cnt), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
